// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction format and fetch FSM state encoding.
// Used by the fetch unit and the instruction decoder.
package cpu_pkg;

    localparam int INSTR_W = 6;

    // Instruction fields: [5:2] opcode, [1:0] register address
    localparam int OP_MSB  = 5;
    localparam int OP_LSB  = 2;
    localparam int REG_MSB = 1;
    localparam int REG_LSB = 0;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2,
        FS_HOLD = 2'd3
    } fetch_state_t;

    function automatic logic [OP_MSB-OP_LSB:0] get_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [REG_MSB-REG_LSB:0] get_reg(input logic [INSTR_W-1:0] instr);
        return instr[REG_MSB:REG_LSB];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: synchronous reset, jump load, and increment
// that wraps silently modulo 2^ADDR_W.
module program_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // A load wins over an increment when both are requested
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: reads instructions from a synchronous ROM and hands them to the
// decoder over a valid/ready handshake, with jump redirect and run/stop control.
module instruction_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc
);

    import cpu_pkg::*;

    fetch_state_t state, next_state;
    logic         pc_load;
    logic         pc_inc;
    logic         capture;
    logic         valid_next;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_addr (jump_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign mem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FS_IDLE;
            instruction <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= next_state;
            instr_valid <= valid_next;
            if (capture) begin
                instruction <= mem_rdata;
            end
        end
    end

    // jump_en takes priority over run and instr_ready in every state
    always_comb begin
        next_state = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        capture    = 1'b0;
        valid_next = instr_valid;
        mem_rd_en  = 1'b0;

        case (state)
            FS_IDLE: begin
                if (jump_en) begin
                    pc_load = 1'b1;
                end else if (run) begin
                    next_state = FS_REQ;
                end
            end
            FS_REQ: begin
                mem_rd_en = 1'b1;
                // Re-issuing from REQ leaves the stale read unused
                if (jump_en) begin
                    pc_load = 1'b1;
                end else begin
                    next_state = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (jump_en) begin
                    pc_load    = 1'b1;
                    next_state = FS_REQ;
                end else begin
                    capture    = 1'b1;
                    pc_inc     = 1'b1;
                    valid_next = 1'b1;
                    next_state = FS_HOLD;
                end
            end
            FS_HOLD: begin
                // A jump treats the held instruction as consumed
                if (jump_en) begin
                    pc_load    = 1'b1;
                    valid_next = 1'b0;
                    next_state = FS_REQ;
                end else if (instr_ready) begin
                    valid_next = 1'b0;
                    next_state = run ? FS_REQ : FS_IDLE;
                end
            end
            default: begin
                next_state = FS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural
// synchronous ROM; expected values are hand-derived from the ROM table.
module tb_instruction_fetch;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;

    logic [INSTR_W-1:0] rom [256];

    int checkCount = 0;
    int passCount  = 0;

    instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data appears the edge after a sampled read strobe
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= rom[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic j,
                                 input logic [ADDR_W-1:0] ja);
        run         = r;
        instr_ready = rdy;
        jump_en     = j;
        jump_addr   = ja;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkHold(input string tag, input logic [INSTR_W-1:0] expInstr,
                             input logic [ADDR_W-1:0] expPc);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd1);
        checkOutput({tag, "_instr"}, 32'(instruction), 32'(expInstr));
        checkOutput({tag, "_pc"}, 32'(pc), 32'(expPc));
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, "_instr"}, 32'(instruction), 32'd0);
        checkOutput({tag, "_pc"}, 32'(pc), 32'd0);
        checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i] = 6'((i * 7 + 3) % 64);
        end
        rom[8'h00] = 6'h1D;
        rom[8'h01] = 6'h05;
        rom[8'h02] = 6'h3F;
        rom[8'h03] = 6'h2A;
        rom[8'h04] = 6'h11;
        rom[8'h10] = 6'h33;
        rom[8'h20] = 6'h0C;
        rom[8'hFF] = 6'h27;
        mem_rdata = '0;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(2);
        checkReset("reset");

        // Start-up latency: valid exactly three edges after run
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick(2);
        checkOutput("latency_early", 32'(instr_valid), 32'd0);
        tick(1);
        checkHold("first", 6'h1D, 8'h01);

        // Back-to-back fetches at one instruction per 3 cycles
        tick(1);
        checkOutput("refetch_rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("refetch_addr", 32'(mem_addr), 32'd1);
        tick(2);
        checkHold("second", 6'h05, 8'h02);
        tick(3);
        checkHold("third", 6'h3F, 8'h03);

        // Backpressure: everything frozen while ready is low
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            checkHold("bp", 6'h3F, 8'h03);
            checkOutput("bp_rd_en", 32'(mem_rd_en), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick(1);
        checkOutput("bp_release_rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("bp_release_addr", 32'(mem_addr), 32'd3);
        tick(2);
        checkHold("fourth", 6'h2A, 8'h04);

        // Jump in WAIT at pc=4: ROM[4] must never appear
        tick(1);
        checkOutput("req4_addr", 32'(mem_addr), 32'd4);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h20);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("jwait_valid", 32'(instr_valid), 32'd0);
        checkOutput("jwait_rd_en", 32'(mem_rd_en), 32'd1);
        checkOutput("jwait_addr", 32'(mem_addr), 32'h20);
        tick(1);
        checkOutput("jwait_no_rom4", 32'(instr_valid), 32'd0);
        tick(1);
        checkHold("jwait_target", 6'h0C, 8'h21);

        // Jump in HOLD with ready low
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h10);
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("jhold_valid", 32'(instr_valid), 32'd0);
        checkOutput("jhold_pc", 32'(pc), 32'h10);
        tick(2);
        checkHold("jhold_target", 6'h33, 8'h11);

        // Wrap-around from 0xFF back to 0
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick(2);
        checkHold("wrap_ff", 6'h27, 8'h00);
        tick(3);
        checkHold("wrap_zero", 6'h1D, 8'h01);

        // run low: consume then idle, instruction retained
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1);
        checkOutput("stop_valid", 32'(instr_valid), 32'd0);
        checkOutput("stop_instr_kept", 32'(instruction), 32'h1D);
        tick(2);
        checkOutput("idle_rd_en", 32'(mem_rd_en), 32'd0);
        checkOutput("idle_pc", 32'(pc), 32'd1);

        // Reset while in WAIT
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
        tick(2);
        rst = 1'b1;
        tick(1);
        checkReset("rst_wait");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput("rst_wait_quiet", 32'(instr_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        tick(3);
        checkHold("after_rst", 6'h1D, 8'h01);

        // Reset while in HOLD
        rst = 1'b1;
        tick(1);
        checkReset("rst_hold");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        tick(4);
        checkOutput("rst_hold_quiet", 32'(instr_valid), 32'd0);
        checkOutput("rst_hold_rd_en", 32'(mem_rd_en), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream feeder of the instruction decoder. Holds the program counter, reads 6-bit instructions from a synchronous program ROM, and presents one instruction at a time to the decoder through a valid/ready handshake. Also handles redirects (jumps), run/stop control and PC wrap-around.

Parameters:
ADDR_W, 8, program counter and ROM address width
INSTR_W, 6, instruction width; must match the decoder's instruction input

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
run  input  1  level; 1 = keep fetching, 0 = stop after the current instruction is consumed
mem_rd_en  output  1  ROM read strobe; combinational, high only in state REQ
mem_addr  output  ADDR_W  ROM address; equals pc
mem_rdata  input  INSTR_W  ROM data; valid the cycle after the edge that sampled mem_rd_en=1
jump_en  input  1  redirect request, single-cycle pulse
jump_addr  input  ADDR_W  redirect target
instruction  output  INSTR_W  registered instruction to the decoder
instr_valid  output  1  instruction holds a live instruction
instr_ready  input  1  decoder accepts instruction this cycle
pc  output  ADDR_W  current program counter

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high and is sampled on the rising edge of clk.
- Reset values: state = IDLE, pc = 0, instruction = 0, instr_valid = 0, mem_rd_en = 0. rst overrides all other inputs and may occur in any state. Any in-flight ROM data is discarded.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - jump_en: pc <= jump_addr; stay in IDLE.
  - else if run: go to REQ.
  - else: stay in IDLE.
- REQ:
  - mem_rd_en = 1 and mem_addr = pc.
  - jump_en: pc <= jump_addr; stay in REQ. This issues a new read; the stale read is ignored.
  - else: go to WAIT.
- WAIT:
  - jump_en: pc <= jump_addr; go to REQ. mem_rdata is discarded and instr_valid stays 0.
  - else: instruction <= mem_rdata, instr_valid <= 1, pc <= pc + 1; go to HOLD.
- HOLD:
  - instruction and instr_valid are held stable while instr_ready = 0.
  - jump_en (with or without ready): the held instruction counts as consumed. instr_valid <= 0, pc <= jump_addr; go to REQ regardless of run.
  - else if instr_ready: instr_valid <= 0; go to REQ if run, otherwise IDLE.
- Jump precedence: jump_en has priority over run and instr_ready in every state.
- Latency and throughput:
  - run rising in IDLE gives instr_valid = 1 three edges later.
  - With ready held high, throughput is one instruction per 3 cycles.
- PC arithmetic:
  - Increment is modulo 2^ADDR_W, so pc = 2^ADDR_W-1 wraps to 0 with no flag.
  - jump_addr is used as-is.
- run = 0 in REQ or WAIT does not abort the fetch. The fetch completes and the instruction is presented; the FSM then returns to IDLE after consumption.
- instruction is updated only in the WAIT->HOLD transition. Its value is retained after consumption.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W = 6.
  - Opcode field positions: [5:2] op, [1:0] register address.
  - Fetch FSM state encoding constants FS_IDLE, FS_REQ, FS_WAIT, FS_HOLD (2-bit).
- The decoder imports INSTR_W from the same package.
- One natural sub-module: program_counter, holding the pc register with load (jump_addr), increment-with-wrap and synchronous reset. Everything else lives in the FSM of instruction_fetch.

Test Plan:
- Reset then run = 1, ROM[0..2] = 6'h1D, 6'h05, 6'h3F, ready always 1:
  - instr_valid first high 3 cycles after run.
  - Instructions 1D, 05, 3F appear in order, one per 3 cycles.
  - pc reads 1, 2, 3 during the respective HOLD cycles.
- Backpressure: ready = 0 for 5 cycles while in HOLD:
  - instruction stays constant and instr_valid stays 1.
  - mem_rd_en stays 0.
  - pc stays unchanged.
  - On ready = 1, the next fetch starts the following cycle.
- Jump in WAIT at pc = 4 with jump_addr = 8'h20:
  - ROM[4] is never presented.
  - mem_rd_en next cycle with mem_addr = 20.
  - The next valid instruction is ROM[0x20].
- Jump in HOLD with ready = 0, jump_addr = 8'h10:
  - instr_valid drops next cycle.
  - The next valid instruction is ROM[0x10] and pc becomes 0x11.
- Wrap: jump to 8'hFF, run = 1:
  - ROM[0xFF] is presented, then pc = 0.
  - The following instruction is ROM[0].
- rst asserted in WAIT and in HOLD:
  - All outputs return to reset values the next cycle.
  - No instruction is presented until run is reasserted after rst = 0.
